// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB3 register-memory completer.
//   apb_slv_state_t : transfer FSM states (idle, wait-state countdown, response)
//   APB_WIN_LG2     : log2 of the 4 KB address window decoded by each completer
//   SLV1_BASE/SLV2_BASE : window bases of the two completers in the system map
package apb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_slv_state_t;

  localparam int          APB_WIN_LG2 = 12;
  localparam logic [31:0] SLV1_BASE   = 32'h0001_F000;
  localparam logic [31:0] SLV2_BASE   = 32'h0002_F000;

endpackage

// File: rtl/apb_slave_mem_regfile.sv
// Word storage for apb_slave_mem: DEPTH x DATA_WIDTH, cleared by reset.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_data : single write port, committed on the rising edge
//   rd_en/rd_idx       : read request; rd_data loads mem[rd_idx] on the next
//                        edge when rd_en=1 and loads 0 otherwise, so the
//                        output register doubles as the zero-gated PRDATA flop
module apb_slave_regfile #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      wr_sel;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // One-hot word write enables.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign wr_sel[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem_q[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory.
// Fixed wait states, PSLVERR on out-of-window / misaligned / out-of-depth
// accesses, and a saturating count of errored transfers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   psel_i, penable_i   : APB select and access-phase strobe
//   pwrite_i            : 1 = write, 0 = read
//   paddr_i, pwdata_i   : byte address and write data
//   prdata_o            : read data, non-zero only in the response cycle
//   pready_o, pslverr_o : transfer completion and error flag
//   err_cnt_o           : saturating errored-transfer count
// All outputs come straight from flops.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(SLV1_BASE),
  parameter int                    DEPTH       = 64,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [7:0]            err_cnt_o
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] DEPTH_L = 11'(DEPTH);

  apb_slv_state_t        state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  rd_en, wr_en;
  logic [IDX_W-1:0]      rd_idx;
  logic                  setup_err;
  logic [IDX_W-1:0]      setup_idx;
  logic [9:0]            setup_off;

  // Address decode of the setup-phase address.
  assign setup_off = paddr_i[APB_WIN_LG2-1:2];
  assign setup_idx = setup_off[IDX_W-1:0];
  assign setup_err = (paddr_i[ADDR_WIDTH-1:APB_WIN_LG2] != BASE_ADDR[ADDR_WIDTH-1:APB_WIN_LG2])
                  || (paddr_i[1:0] != 2'b00)
                  || ({1'b0, setup_off} >= DEPTH_L);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    err_cnt_d = err_cnt_q;
    rd_en     = 1'b0;
    rd_idx    = idx_q;
    wr_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // penable_i without a preceding setup cycle is ignored here.
        if (psel_i && !penable_i) begin
          idx_d   = setup_idx;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          err_d   = setup_err;
          wcnt_d  = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            // Zero wait states: response flops load straight from the bus.
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            rd_en     = !pwrite_i && !setup_err;
            rd_idx    = setup_idx;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            rd_en     = !write_q && !err_q;
            rd_idx    = idx_q;
          end
        end
      end

      ST_RESP: begin
        // The response cycle always ends here; only a live access commits.
        state_d = ST_IDLE;
        if (psel_i && penable_i) begin
          wr_en = write_q && !err_q;
          if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  apb_slave_regfile #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (prdata_o)
  );

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Three completers: dut0 WAIT_STATES=1 @SLV1, dut1 WAIT_STATES=0 @SLV1,
// dut2 WAIT_STATES=3 @SLV2. Directed transfers pin literal values, then
// random traffic runs against a memory-array model of the address map.
module tb_apb_slave_mem;
  import apb_slave_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [N];
  logic        psel    [N];
  logic        penable [N];
  logic        pwrite  [N];
  logic [31:0] paddr   [N];
  logic [31:0] pwdata  [N];
  logic [31:0] prdata  [N];
  logic        pready  [N];
  logic        pslverr [N];
  logic [7:0]  err_cnt [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      apb_slave_mem #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .BASE_ADDR   ((gi == 2) ? SLV2_BASE : SLV1_BASE),
        .DEPTH       (64),
        .WAIT_STATES ((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n[gi]),
        .psel_i    (psel[gi]),
        .penable_i (penable[gi]),
        .pwrite_i  (pwrite[gi]),
        .paddr_i   (paddr[gi]),
        .pwdata_i  (pwdata[gi]),
        .prdata_o  (prdata[gi]),
        .pready_o  (pready[gi]),
        .pslverr_o (pslverr[gi]),
        .err_cnt_o (err_cnt[gi])
      );
    end
  endgenerate

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m   [N][64];
  int          cnt_m   [N];
  int          resp_at [N];   // cycle number in which pready is expected
  logic        exp_err [N];
  logic        exp_wr  [N];
  logic [31:0] exp_rd  [N];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  bit chk_on = 1'b0;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? SLV2_BASE : SLV1_BASE;
  endfunction

  // Legal iff inside the 4 KB window, word aligned, word index below 64.
  function automatic logic model_err(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(k);
    return (off >= 32'd4096) || ((off % 4) != 0) || ((off / 4) >= 64);
  endfunction

  function automatic int model_idx(input int k, input logic [31:0] a);
    return int'((a - base_of(k)) / 4);
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 64; i++) mem_m[k][i] = '0;
    cnt_m[k]   = 0;
    resp_at[k] = -1;
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, k, act, exp, $time);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < N; k++) begin
        bit er;
        er = (cyc == resp_at[k]);
        chk("pready", k, 32'(pready[k]), 32'(er));
        if (er) begin
          chk("pslverr", k, 32'(pslverr[k]), 32'(exp_err[k]));
          if (!exp_wr[k]) chk("prdata", k, prdata[k], exp_rd[k]);
        end else begin
          chk("prdata_idle", k, prdata[k], 32'h0);
        end
        chk("err_cnt", k, 32'(err_cnt[k]), 32'(cnt_m[k]));
      end
    end
  end

  // ---------------- drivers (enter and leave at posedge+1) ----------------
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit abort, output logic [31:0] rdata, output logic err, output int lat);
    int   c0;
    int   n;
    logic e;
    c0 = cyc;
    e  = model_err(k, addr);
    resp_at[k] = c0 + 1 + ws_of(k);
    exp_err[k] = e;
    exp_wr[k]  = wr;
    exp_rd[k]  = (e || wr) ? 32'h0 : mem_m[k][model_idx(k, addr)];
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = data;
    @(posedge clk) #1;
    rdata = '0; err = 1'b0; lat = 0;
    if (abort) begin
      // With wait states the abort lands in WAIT and no response appears.
      psel[k] = 1'b0;
      if (ws_of(k) != 0) resp_at[k] = -1;
      @(posedge clk) #1;
      $display("dut%0d abort %s addr=%h", k, wr ? "wr" : "rd", addr);
    end else begin
      penable[k] = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!pready[k] && n < 40);
      if (!pready[k]) chk("pready_timeout", k, 32'(pready[k]), 32'h1);
      rdata = prdata[k];
      err   = pslverr[k];
      lat   = cyc - c0;
      @(posedge clk) #1;
      psel[k] = 1'b0; penable[k] = 1'b0;
      if (!e && wr) mem_m[k][model_idx(k, addr)] = data;
      if (e && cnt_m[k] < 255) cnt_m[k]++;
      $display("dut%0d %s addr=%h wdata=%h rdata=%h err=%0b lat=%0d", k, wr ? "wr" : "rd",
               addr, data, rdata, err, lat);
    end
  endtask

  // penable without setup: must be ignored.
  task automatic glitch(input int k, input logic [31:0] addr);
    psel[k] = 1'b1; penable[k] = 1'b1; pwrite[k] = 1'b1; paddr[k] = addr; pwdata[k] = 32'hBAD0_BAD0;
    @(posedge clk) #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
    $display("dut%0d penable-without-setup addr=%h", k, addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] a;
    int          r;

    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0;
      model_reset(k);
    end
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_pready", k, 32'(pready[k]), 32'h0);
      chk("rst_err_cnt", k, 32'(err_cnt[k]), 32'h0);
      rst_n[k] = 1'b1;
    end
    @(posedge clk) #1;

    // dut0, one wait state
    xfer(0, 1'b1, 32'h0001_F010, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
    chk("t1_lat", 0, 32'(lat), 32'd2);
    chk("t1_err", 0, 32'(er), 32'h0);
    xfer(0, 1'b0, 32'h0001_F010, 32'h0, 1'b0, rd, er, lat);
    chk("t2_rdata", 0, rd, 32'hDEAD_BEEF);
    chk("t2_lat", 0, 32'(lat), 32'd2);
    xfer(0, 1'b0, 32'h0001_F002, 32'h0, 1'b0, rd, er, lat);
    chk("t3_misalign_err", 0, 32'(er), 32'h1);
    chk("t3_misalign_rdata", 0, rd, 32'h0);
    xfer(0, 1'b0, 32'h0001_F100, 32'h0, 1'b0, rd, er, lat);
    chk("t3_depth_err", 0, 32'(er), 32'h1);
    chk("t3_err_cnt", 0, 32'(err_cnt[0]), 32'd2);
    xfer(0, 1'b1, 32'h0002_F000, 32'h1234_5678, 1'b0, rd, er, lat);
    chk("t4_base_err", 0, 32'(er), 32'h1);
    xfer(0, 1'b0, 32'h0001_F000, 32'h0, 1'b0, rd, er, lat);
    chk("t4_rdata", 0, rd, 32'h0);
    chk("t4_err", 0, 32'(er), 32'h0);
    glitch(0, 32'h0001_F004);
    xfer(0, 1'b0, 32'h0001_F004, 32'h0, 1'b0, rd, er, lat);
    chk("glitch_no_write", 0, rd, 32'h0);

    // reset pulse during WAIT of a write
    resp_at[0] = cyc + 2; exp_err[0] = 1'b0; exp_wr[0] = 1'b1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h0001_F020; pwdata[0] = 32'h5555_AAAA;
    @(posedge clk) #1;
    penable[0] = 1'b1;
    #2 rst_n[0] = 1'b0;
    model_reset(0);
    #1;
    chk("t6_rst_pready", 0, 32'(pready[0]), 32'h0);
    chk("t6_rst_prdata", 0, prdata[0], 32'h0);
    chk("t6_rst_err_cnt", 0, 32'(err_cnt[0]), 32'h0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clk) #1;
    rst_n[0] = 1'b1;
    @(posedge clk) #1;
    xfer(0, 1'b0, 32'h0001_F020, 32'h0, 1'b0, rd, er, lat);
    chk("t6_word_unchanged", 0, rd, 32'h0);
    xfer(0, 1'b0, 32'h0001_F010, 32'h0, 1'b0, rd, er, lat);
    chk("t6_storage_cleared", 0, rd, 32'h0);
    xfer(0, 1'b1, 32'h0001_F020, 32'hA5A5_0001, 1'b0, rd, er, lat);
    xfer(0, 1'b0, 32'h0001_F020, 32'h0, 1'b0, rd, er, lat);
    chk("t6_after_reset", 0, rd, 32'hA5A5_0001);
    chk("t6_lat", 0, 32'(lat), 32'd2);

    // back-to-back words 0..3 on dut1 (0 waits) and dut2 (3 waits)
    for (int k = 1; k < N; k++) begin
      for (int i = 0; i < 4; i++) begin
        xfer(k, 1'b1, base_of(k) + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, rd, er, lat);
        chk("t5_wr_lat", k, 32'(lat), (k == 1) ? 32'd1 : 32'd4);
      end
      for (int i = 0; i < 4; i++) begin
        xfer(k, 1'b0, base_of(k) + 32'(4 * i), 32'h0, 1'b0, rd, er, lat);
        chk("t5_rd_lat", k, 32'(lat), (k == 1) ? 32'd1 : 32'd4);
        chk("t5_rdata", k, rd, 32'hC0DE_0000 + 32'(i));
      end
    end

    // err_cnt saturation on dut1
    for (int i = 0; i < 260; i++) xfer(1, 1'b0, SLV1_BASE + 32'd2, 32'h0, 1'b0, rd, er, lat);
    chk("sat_err_cnt", 1, 32'(err_cnt[1]), 32'd255);

    // random traffic
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 80; t++) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2, 3, 4, 5: a = base_of(k) + 32'($urandom_range(0, 15) * 4);
          6:                a = base_of(k) + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(1, 3));
          7:                a = base_of(k) + 32'($urandom_range(64, 1023) * 4);
          8:                a = (base_of(k) ^ 32'($urandom_range(1, 15) << 12)) + 32'($urandom_range(0, 15) * 4);
          default:          a = $urandom & 32'hFFFF_FFFC;
        endcase
        if ($urandom_range(0, 11) == 0) glitch(k, a);
        xfer(k, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 9) == 0), rd, er, lat);
        repeat ($urandom_range(0, 2)) @(posedge clk) #1;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
